// File: rtl/acc_reg_bank_if.sv
// acc_reg_bank_if: write/read/dump port bundle of the accumulator register bank
interface acc_reg_bank_if #(
   parameter int WIDTH  = 19,
   parameter int NUM_CH = 4
);
   localparam int CW = $clog2(NUM_CH);
   logic              en;
   logic [CW-1:0]     ch_sel;
   logic [1:0]        op;
   logic [WIDTH-1:0]  PI;
   logic [CW-1:0]     rd_sel;
   logic [WIDTH-1:0]  PO;
   logic [NUM_CH-1:0] ovf;
   logic              dump_start;
   logic              busy;
   logic              dump_valid;
   logic [CW-1:0]     dump_ch;
   logic [WIDTH-1:0]  dump_data;
   modport master (
      output en, ch_sel, op, PI, rd_sel, dump_start,
      input  PO, ovf, busy, dump_valid, dump_ch, dump_data
   );
   modport slave (
      input  en, ch_sel, op, PI, rd_sel, dump_start,
      output PO, ovf, busy, dump_valid, dump_ch, dump_data
   );
endinterface

// File: rtl/acc_reg_bank.sv
// acc_reg_bank: NUM_CH saturating accumulator registers with a sequential dump streamer
module acc_reg_bank #(
   parameter int WIDTH  = 19,
   parameter int NUM_CH = 4
) (
   input logic           clk,
   input logic           rst,
   acc_reg_bank_if.slave bus
);
   localparam int CW = $clog2(NUM_CH);
   typedef enum logic {IDLE, DUMP} state_t;
   state_t           state, state_nx;
   logic [CW-1:0]    k, k_nx;
   logic [WIDTH-1:0] regs [NUM_CH];
   logic [WIDTH-1:0] cur;
   logic [WIDTH:0]   sum;
   logic             sel_ok, rd_ok;
   assign sel_ok   = {1'b0, bus.ch_sel} < (CW+1)'(NUM_CH);
   assign rd_ok    = {1'b0, bus.rd_sel} < (CW+1)'(NUM_CH);
   assign cur      = sel_ok ? regs[bus.ch_sel] : '0;
   assign sum      = {1'b0, cur} + {1'b0, bus.PI};
   assign bus.PO   = rd_ok ? regs[bus.rd_sel] : '0;
   assign bus.busy = state == DUMP;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) regs[i] <= '0;
         bus.ovf <= '0;
      end else if (bus.en && sel_ok) begin
         case (bus.op)
            2'b01: begin
               regs[bus.ch_sel]    <= bus.PI;
               bus.ovf[bus.ch_sel] <= 1'b0;
            end
            2'b10: begin
               regs[bus.ch_sel] <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
               if (sum[WIDTH]) bus.ovf[bus.ch_sel] <= 1'b1;
            end
            2'b11: begin
               regs[bus.ch_sel]    <= '0;
               bus.ovf[bus.ch_sel] <= 1'b0;
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         k              <= '0;
         bus.dump_valid <= 1'b0;
         bus.dump_ch    <= '0;
         bus.dump_data  <= '0;
      end else begin
         state          <= state_nx;
         k              <= k_nx;
         bus.dump_valid <= state == DUMP;
         if (state == DUMP) begin
            bus.dump_ch   <= k;
            bus.dump_data <= regs[k];
         end
      end
   end
   always_comb begin
      state_nx = state;
      k_nx     = k;
      if (state == IDLE) begin
         state_nx = bus.dump_start ? DUMP : IDLE;
         k_nx     = '0;
      end else begin
         state_nx = (k == CW'(NUM_CH - 1)) ? IDLE : DUMP;
         k_nx     = (k == CW'(NUM_CH - 1)) ? k : k + 1'b1;
      end
   end
endmodule

// File: tb/tb_acc_reg_bank.sv
// tb_acc_reg_bank: directed stimulus with a dump-beat scoreboard and direct read checks
module tb_acc_reg_bank;
   localparam int WIDTH  = 8;
   localparam int NUM_CH = 4;
   localparam int CW     = 2;
   logic clk, rst;
   int checks = 0, errors = 0;
   logic [CW+WIDTH-1:0] exp_q [$];
   acc_reg_bank_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();
   acc_reg_bank #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (.clk(clk), .rst(rst), .bus(bus));
   initial clk = 0;
   always #5 clk = ~clk;
   // Monitor: every presented dump beat must match the oldest expected beat
   always @(negedge clk) begin
      if (bus.dump_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected got ch=%0d data=%0h required none", bus.dump_ch, bus.dump_data);
         end else begin
            logic [CW+WIDTH-1:0] e;
            e = exp_q.pop_front();
            if ({bus.dump_ch, bus.dump_data} !== e) begin
               errors++;
               $display("FAIL beat got ch=%0d data=%0h required ch=%0d data=%0h",
                        bus.dump_ch, bus.dump_data, e[CW+WIDTH-1:WIDTH], e[WIDTH-1:0]);
            end
         end
      end
   end
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h required %0h", name, got, exp);
      end
   endtask
   task automatic do_op(input int ch, input logic [1:0] o, input int d, input logic e);
      bus.en = e; bus.ch_sel = CW'(ch); bus.op = o; bus.PI = WIDTH'(d);
      @(posedge clk); #1;
      bus.en = 0; bus.op = 2'b00;
   endtask
   task automatic rd(input int ch, input string name, input int exp);
      bus.rd_sel = CW'(ch); #1;
      chk(name, 32'(bus.PO), exp);
   endtask
   task automatic push(input int ch, input int d);
      exp_q.push_back({CW'(ch), WIDTH'(d)});
   endtask
   task automatic start_dump;
      bus.dump_start = 1;
      @(posedge clk); #1;
      bus.dump_start = 0;
   endtask
   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, exp_q.size(), 0);
   endtask
   initial begin
      rst = 1;
      bus.en = 0; bus.ch_sel = 0; bus.op = 0; bus.PI = 0; bus.rd_sel = 0; bus.dump_start = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      // 1: async reset mid-cycle
      do_op(0, 2'b01, 'h5A, 1);
      rd(0, "pre_rst_po", 'h5A);
      start_dump();
      chk("pre_rst_busy", bus.busy, 1);
      #2 rst = 1;
      #1;
      chk("rst_po", bus.PO, 0);
      chk("rst_ovf", bus.ovf, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.dump_valid, 0);
      @(posedge clk); #1 rst = 0;
      // 2: load and enable gating
      do_op(2, 2'b01, 'h11, 1);
      do_op(2, 2'b01, 'h22, 0);
      rd(2, "en_gate_po2", 'h11);
      rd(0, "other_po0", 0);
      rd(1, "other_po1", 0);
      rd(3, "other_po3", 0);
      // 3: saturation and sticky ovf
      do_op(1, 2'b01, 250, 1);
      do_op(1, 2'b10, 5, 1);
      rd(1, "acc_255", 255);
      chk("acc_no_ovf", bus.ovf, 0);
      do_op(1, 2'b10, 1, 1);
      rd(1, "acc_sat", 255);
      chk("acc_ovf", bus.ovf, 4'b0010);
      do_op(1, 2'b10, 2, 1);
      chk("ovf_sticky", bus.ovf, 4'b0010);
      do_op(1, 2'b01, 3, 1);
      rd(1, "load_after_sat", 3);
      chk("load_clr_ovf", bus.ovf, 0);
      do_op(2, 2'b11, 0, 1);
      rd(2, "clr", 0);
      // 4: dump stream
      for (int i = 0; i < NUM_CH; i++) do_op(i, 2'b01, i + 1, 1);
      for (int i = 0; i < NUM_CH; i++) push(i, i + 1);
      start_dump();
      chk("dump_busy", bus.busy, 1);
      chk("dump_valid_lag", bus.dump_valid, 0);
      drain("dump_beats");
      chk("dump_end_valid", bus.dump_valid, 0);
      chk("dump_end_busy", bus.busy, 0);
      // 5: start while busy ignored; write during dump shows old value
      for (int i = 0; i < NUM_CH; i++) push(i, i + 1);
      start_dump();
      @(posedge clk); #1;
      bus.dump_start = 1;
      @(posedge clk); #1;
      bus.dump_start = 0;
      do_op(2, 2'b10, 10, 1);
      drain("redump_beats");
      repeat (6) @(posedge clk);
      #1;
      chk("no_restart", bus.dump_valid, 0);
      rd(2, "acc_during_dump", 13);
      // 6: reset during a dump
      push(0, 1);
      push(1, 2);
      start_dump();
      repeat (3) @(posedge clk);
      #2 rst = 1;
      #1;
      chk("rst_dump_valid", bus.dump_valid, 0);
      chk("rst_dump_busy", bus.busy, 0);
      chk("rst_dump_q", exp_q.size(), 0);
      exp_q.delete();
      @(posedge clk); #1 rst = 0;
      for (int i = 0; i < NUM_CH; i++) push(i, 0);
      start_dump();
      drain("zero_beats");
      repeat (3) @(posedge clk);
      #1;
      chk("final_q", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
